// File: rtl/aritm_pkg.sv
// Shared constants for the arithmetic group: digit width and FSM encodings.
package aritm_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/borrow_lookahead4.sv
// 4-bit borrow-lookahead subtract slice: d = x - y - bi, with borrow-out bo.
// Every borrow is a flat sum-of-products of generate/propagate terms and bi.
module borrow_lookahead4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] bor;

  // Generate when x_i=0,y_i=1; propagate an incoming borrow when x_i==y_i.
  always_comb begin
    g = ~x & y;
    p = ~(x ^ y);
    bor[0] = bi;
    bor[1] = g[0] | (p[0] & bi);
    bor[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    bor[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
    bor[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & bi);
    d  = x ^ y ^ bor[3:0];
    bo = bor[4];
  end

endmodule

// File: rtl/scadere_serial.sv
// Digit-serial subtractor: diff = a - b - b_in, one 4-bit digit per clock,
// borrow registered between digits. Flags registered on entry to DONE.
//
// Handshake: start is sampled only while idle (busy=0); the operands and b_in
// are latched on that edge. done pulses for one cycle when diff/b_out/ovf/zero
// are valid; the results then hold until the next accepted start.
module scadere_serial
  import aritm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int NDIG = WIDTH / DIGIT_W;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             bor_q, bor_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT_W-1:0] slice_x, slice_y, slice_d;
  logic               slice_bo;

  // Present the digit selected by idx to the single lookahead slice.
  always_comb begin
    slice_x = a_q[idx_q*DIGIT_W +: DIGIT_W];
    slice_y = b_q[idx_q*DIGIT_W +: DIGIT_W];
  end

  borrow_lookahead4 u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .bi (bor_q),
    .d  (slice_d),
    .bo (slice_bo)
  );

  // Next-state logic: FSM, digit counter, operand latch, result and flags.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    bor_d   = bor_q;
    diff_d  = diff_q;
    b_out_d = b_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          bor_d   = b_in;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        diff_d[idx_q*DIGIT_W +: DIGIT_W] = slice_d;
        bor_d = slice_bo;
        if (idx_q == LAST) begin
          state_d = S_DONE;
          b_out_d = slice_bo;
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = ~|diff_d;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset clears results too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bor_q   <= 1'b0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bor_q   <= bor_d;
      diff_q  <= diff_d;
      b_out_q <= b_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Output mapping.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    diff      = diff_q;
    b_out     = b_out_q;
    ovf       = ovf_q;
    zero      = zero_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_scadere_serial.sv
// Bench for scadere_serial: a 16-bit instance (directed, protocol, random)
// and a 4-bit instance (exhaustive), both checked against an arithmetic model.
module tb_scadere_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // 16-bit DUT signals
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        bin16 = 1'b0;
  logic        busy16, done16, bout16, ovf16, zero16;
  logic [15:0] diff16;
  logic [1:0]  st16;

  // 4-bit DUT signals
  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        bin4 = 1'b0;
  logic        busy4, done4, bout4, ovf4, zero4;
  logic [3:0]  diff4;
  logic [1:0]  st4;

  logic [18:0] exp_q16[$];
  logic [6:0]  exp_q4[$];
  int ops16 = 0, ops4 = 0, done_cnt16 = 0, done_cnt4 = 0;

  scadere_serial #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .b_in(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .b_out(bout16), .ovf(ovf16),
    .zero(zero16), .dbg_state(st16)
  );

  scadere_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .b_in(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .b_out(bout4), .ovf(ovf4),
    .zero(zero4), .dbg_state(st4)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  // Returns {diff[15:0], b_out, ovf, zero}; for narrow widths diff is in the low bits.
  function automatic logic [18:0] ref_model(int w, longint av, longint bv, longint bi);
    longint m, u, d, sa, sb, sr;
    logic bo, ov, z;
    m  = longint'(1) << w;
    u  = av - bv - bi;
    bo = (u < 0);
    d  = (u + m) % m;
    sa = (av >= m / 2) ? av - m : av;
    sb = (bv >= m / 2) ? bv - m : bv;
    sr = sa - sb - bi;
    ov = (sr < -(m / 2)) || (sr > (m / 2 - 1));
    z  = (d == 0);
    return {d[15:0], bo, ov, z};
  endfunction

  // scoreboard monitors: pop on every done pulse
  always @(negedge clk) begin
    logic [18:0] e;
    if (done16) begin
      done_cnt16++;
      if (exp_q16.size() == 0) begin
        chk("unexpected_done16", 32'd1, 32'd0);
      end else begin
        e = exp_q16.pop_front();
        chk("result16", {13'd0, diff16, bout16, ovf16, zero16}, {13'd0, e});
      end
    end
  end

  always @(negedge clk) begin
    logic [6:0] e;
    if (done4) begin
      done_cnt4++;
      if (exp_q4.size() == 0) begin
        chk("unexpected_done4", 32'd1, 32'd0);
      end else begin
        e = exp_q4.pop_front();
        chk("result4", {25'd0, diff4, bout4, ovf4, zero4}, {25'd0, e});
      end
    end
  end

  // driver tasks (all entered and left on a negedge)
  task automatic wait_idle16();
    int n = 0;
    while (busy16 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy16) chk("idle16_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done16(output int at);
    int n = 0;
    at = -1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done16) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("done16_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue16(input logic [15:0] av, input logic [15:0] bv, input logic bi, input bit poke);
    int t0, tdone;
    logic [18:0] e;
    wait_idle16();
    a16 = av; b16 = bv; bin16 = bi; start16 = 1'b1;
    e = ref_model(16, longint'(av), longint'(bv), longint'(bi));
    exp_q16.push_back(e);
    ops16++;
    t0 = cyc;
    @(negedge clk);
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
    chk("busy_after_start", {31'd0, busy16}, 32'd1);
    if (poke) begin
      @(negedge clk);
      start16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
      @(negedge clk);
      start16 = 1'b0;
    end
    wait_done16(tdone);
    if (tdone >= 0) chk("latency16", tdone - t0, 32'd5);
    @(negedge clk);
    @(negedge clk);
    chk("diff_hold16", {16'd0, diff16}, {16'd0, e[18:3]});
    chk("busy_idle16", {31'd0, busy16}, 32'd0);
  endtask

  task automatic issue4(input logic [3:0] av, input logic [3:0] bv, input logic bi);
    int t0, n;
    logic [18:0] e;
    n = 0;
    while (busy4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    a4 = av; b4 = bv; bin4 = bi; start4 = 1'b1;
    e = ref_model(4, longint'(av), longint'(bv), longint'(bi));
    exp_q4.push_back({e[6:3], e[2:0]});
    ops4++;
    t0 = cyc;
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom);
    n = 0;
    while (!done4 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!done4) chk("done4_timeout", 32'd1, 32'd0);
    else chk("latency4", cyc - t0, 32'd2);
    @(negedge clk);
  endtask

  // main stimulus
  initial begin
    int t1, t2;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs16", {26'd0, busy16, done16, bout16, ovf16, zero16, (diff16 != 0)}, 32'd0);
    chk("reset_state16", {30'd0, st16}, 32'd0);
    chk("reset_outputs4", {26'd0, busy4, done4, bout4, ovf4, zero4, (diff4 != 0)}, 32'd0);

    // directed cases; the first also has start poked mid-run
    issue16(16'h1234, 16'h0234, 1'b0, 1'b1);
    issue16(16'h0000, 16'h0001, 1'b0, 1'b0);
    issue16(16'h8000, 16'h0001, 1'b0, 1'b0);
    issue16(16'h5555, 16'h5554, 1'b1, 1'b0);
    issue16(16'h5555, 16'h5555, 1'b1, 1'b0);
    issue16(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
    issue16(16'h0000, 16'hFFFF, 1'b1, 1'b0);

    // start held high across two back-to-back operations
    wait_idle16();
    a16 = 16'hA5A5; b16 = 16'h0F0F; bin16 = 1'b1; start16 = 1'b1;
    exp_q16.push_back(ref_model(16, 64'hA5A5, 64'h0F0F, 1));
    ops16++;
    @(negedge clk);
    a16 = 16'h0100; b16 = 16'h0200; bin16 = 1'b0;
    exp_q16.push_back(ref_model(16, 64'h0100, 64'h0200, 0));
    ops16++;
    wait_done16(t1);
    wait_done16(t2);
    start16 = 1'b0;
    if (t1 >= 0 && t2 >= 0) chk("held_start_gap", t2 - t1, 32'd6);
    @(negedge clk);
    @(negedge clk);

    // reset in the middle of a run: no done pulse, outputs cleared
    wait_idle16();
    a16 = 16'hFFFF; b16 = 16'h1234; bin16 = 1'b1; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy16", {31'd0, busy16}, 32'd0);
    chk("rst_done16", {31'd0, done16}, 32'd0);
    chk("rst_result16", {13'd0, diff16, bout16, ovf16, zero16}, 32'd0);
    repeat (8) @(negedge clk);
    chk("rst_no_done", done_cnt16, ops16);

    // reset wins over start
    rst = 1'b1; start16 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start16 = 1'b0;
    chk("rst_over_start", {31'd0, busy16}, 32'd0);
    @(negedge clk);

    // random operations with occasional mid-run pokes
    for (int i = 0; i < 40; i++) begin
      issue16(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    // exhaustive 4-bit build
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          issue4(4'(ai), 4'(bi), 1'(ci));

    repeat (10) @(negedge clk);
    chk("done_count16", done_cnt16, ops16);
    chk("done_count4", done_cnt4, ops4);
    chk("queue16_empty", exp_q16.size(), 32'd0);
    chk("queue4_empty", exp_q4.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
